// File: rtl/babbage_diff_init.sv
// Seed-column initializer for the Babbage difference engine: Horner-evaluates the
// quintic at n = 0..5, then reduces the table in place to forward differences.
module babbage_diff_init (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  a,
    input  logic [2:0]  b,
    input  logic [3:0]  c,
    input  logic [3:0]  d,
    input  logic [5:0]  f,
    input  logic [9:0]  g,
    output logic        ready,
    output logic        done_tick,
    output logic [31:0] del0,
    output logic [31:0] del1,
    output logic [31:0] del2,
    output logic [31:0] del3,
    output logic [31:0] del4,
    output logic [31:0] del5
);

    typedef enum logic [1:0] {IDLE, EVAL, DIFF, DONE} state_t;

    state_t      state;
    logic [31:0] coef [6];
    logic [31:0] tab  [6];
    logic [31:0] acc;
    logic [2:0]  x;
    logic [2:0]  k;
    logic [2:0]  p;

    logic [31:0] horner_in;
    logic [31:0] addend;
    logic [31:0] mac;

    // One Horner step; the low 32 bits of the product are the same for signed or unsigned x.
    always_comb begin
        horner_in = (k == 3'd0) ? coef[0] : acc;
        case (k)
            3'd0:    addend = coef[1];
            3'd1:    addend = coef[2];
            3'd2:    addend = coef[3];
            3'd3:    addend = coef[4];
            default: addend = coef[5];
        endcase
        mac = horner_in * {29'd0, x} + addend;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            ready     <= 1'b1;
            done_tick <= 1'b0;
            acc       <= '0;
            x         <= '0;
            k         <= '0;
            p         <= '0;
            for (int i = 0; i < 6; i++) begin
                coef[i] <= '0;
                tab[i]  <= '0;
            end
        end else begin
            done_tick <= 1'b0;
            case (state)
                // DONE shares the accept path so a held start restarts with no idle gap.
                IDLE, DONE: begin
                    if (start) begin
                        coef[0] <= {{30{a[1]}}, a};
                        coef[1] <= {{29{b[2]}}, b};
                        coef[2] <= {{28{c[3]}}, c};
                        coef[3] <= {{28{d[3]}}, d};
                        coef[4] <= {{26{f[5]}}, f};
                        coef[5] <= {{22{g[9]}}, g};
                        x       <= '0;
                        k       <= '0;
                        ready   <= 1'b0;
                        state   <= EVAL;
                    end else begin
                        ready <= 1'b1;
                        state <= IDLE;
                    end
                end
                EVAL: begin
                    if (k == 3'd4) begin
                        tab[x] <= mac;
                        k      <= '0;
                        if (x == 3'd5) begin
                            x     <= '0;
                            p     <= 3'd1;
                            state <= DIFF;
                        end else begin
                            x <= x + 3'd1;
                        end
                    end else begin
                        acc <= mac;
                        k   <= k + 3'd1;
                    end
                end
                DIFF: begin
                    for (int i = 1; i < 6; i++) begin
                        if (3'(i) >= p) begin
                            tab[i] <= tab[i] - tab[i-1];
                        end
                    end
                    if (p == 3'd5) begin
                        done_tick <= 1'b1;
                        state     <= DONE;
                    end else begin
                        p <= p + 3'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign del0 = tab[0];
    assign del1 = tab[1];
    assign del2 = tab[2];
    assign del3 = tab[3];
    assign del4 = tab[4];
    assign del5 = tab[5];

endmodule

// File: tb/tb_babbage_diff_init.sv
// Self-checking bench for babbage_diff_init: constant vector table, randomized runs
// against a 64-bit forward-difference model, and hand-written busy/reset sequences.
module tb_babbage_diff_init;

    logic        clk;
    logic        reset;
    logic        start;
    logic [1:0]  a;
    logic [2:0]  b;
    logic [3:0]  c;
    logic [3:0]  d;
    logic [5:0]  f;
    logic [9:0]  g;
    logic        ready;
    logic        done_tick;
    logic [31:0] del0, del1, del2, del3, del4, del5;

    int vectors;
    int miscompares;

    typedef struct packed {
        int ca;
        int cb;
        int cc;
        int cd;
        int cf;
        int cg;
        logic [5:0][31:0] exp;
    } vec_t;

    vec_t             vecs [3];
    logic [5:0][31:0] golden;

    babbage_diff_init dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .a         (a),
        .b         (b),
        .c         (c),
        .d         (d),
        .f         (f),
        .g         (g),
        .ready     (ready),
        .done_tick (done_tick),
        .del0      (del0),
        .del1      (del1),
        .del2      (del2),
        .del3      (del3),
        .del4      (del4),
        .del5      (del5)
    );

    initial clk = 1'b0;
    always #50 clk = ~clk;

    function automatic vec_t mkVec(input int ca, cb, cc, cd, cf, cg,
                                   input int e0, e1, e2, e3, e4, e5);
        vec_t v;
        v.ca = ca; v.cb = cb; v.cc = cc; v.cd = cd; v.cf = cf; v.cg = cg;
        v.exp[0] = e0; v.exp[1] = e1; v.exp[2] = e2;
        v.exp[3] = e3; v.exp[4] = e4; v.exp[5] = e5;
        return v;
    endfunction

    // Evaluate u(0..5) directly, then take the leading entry of each difference row.
    function automatic void computeGolden(input int ca, cb, cc, cd, cf, cg);
        longint u [6];
        for (int n = 0; n < 6; n++) begin
            longint nn = longint'(n);
            u[n] = ca*nn*nn*nn*nn*nn + cb*nn*nn*nn*nn + cc*nn*nn*nn + cd*nn*nn + cf*nn + cg;
        end
        for (int row = 0; row < 6; row++) begin
            golden[row] = u[0][31:0];
            for (int i = 0; i < 5 - row; i++) u[i] = u[i+1] - u[i];
        end
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        vectors++;
        if (actual != expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic checkDels(input string tag, input logic [5:0][31:0] exp);
        checkOutput({tag, "_del0"}, del0, exp[0]);
        checkOutput({tag, "_del1"}, del1, exp[1]);
        checkOutput({tag, "_del2"}, del2, exp[2]);
        checkOutput({tag, "_del3"}, del3, exp[3]);
        checkOutput({tag, "_del4"}, del4, exp[4]);
        checkOutput({tag, "_del5"}, del5, exp[5]);
    endtask

    task automatic driveCoef(input int ca, cb, cc, cd, cf, cg);
        a = 2'(ca); b = 3'(cb); c = 4'(cc); d = 4'(cd); f = 6'(cf); g = 10'(cg);
    endtask

    // Called #1 after a clock edge; returns edges from start edge to first done_tick, -1 on timeout.
    task automatic applyStimulus(input int ca, cb, cc, cd, cf, cg, output int done_edge);
        driveCoef(ca, cb, cc, cd, cf, cg);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        driveCoef(0, 0, 0, 0, 0, 0);
        done_edge = -1;
        for (int n = 1; n <= 60; n++) begin
            @(posedge clk); #1;
            if (done_tick) begin
                done_edge = n;
                break;
            end
        end
    endtask

    task automatic finishRun(input string tag);
        @(posedge clk); #1;
        checkOutput({tag, "_tick_clear"}, done_tick, 0);
        checkOutput({tag, "_ready_back"}, ready, 1);
    endtask

    initial begin
        int done_edge;
        int ticks;
        int tick_edge;
        logic [5:0][31:0] zero_col;
        vectors     = 0;
        miscompares = 0;
        zero_col    = '0;

        vecs[0] = mkVec(-1, 2, 5, 7, 29, 219,   219, 42, 42, -48, -192, -120);
        vecs[1] = mkVec( 1, 0, 0, 0,  0,   0,     0,  1, 30, 150,  240,  120);
        vecs[2] = mkVec( 0, 0, 0, 0,  0,-512,  -512,  0,  0,   0,    0,    0);

        reset = 1'b1;
        start = 1'b0;
        driveCoef(0, 0, 0, 0, 0, 0);
        #100;
        checkOutput("rst_ready", ready, 1);
        checkOutput("rst_done", done_tick, 0);
        checkDels("rst", zero_col);

        // Asynchronous reset landing mid-cycle while EVAL is running.
        #20;
        reset = 1'b0;
        driveCoef(-1, 2, 5, 7, 29, 219);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        #253;
        checkOutput("busy_before_async", ready, 0);
        #1 reset = 1'b1;
        #1;
        checkOutput("async_ready", ready, 1);
        checkOutput("async_done", done_tick, 0);
        checkDels("async", zero_col);
        #14 reset = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 3; i++) begin
            applyStimulus(vecs[i].ca, vecs[i].cb, vecs[i].cc, vecs[i].cd, vecs[i].cf, vecs[i].cg,
                          done_edge);
            checkOutput($sformatf("tab%0d_latency", i), done_edge, 35);
            checkDels($sformatf("tab%0d", i), vecs[i].exp);
            finishRun($sformatf("tab%0d", i));
        end

        for (int r = 0; r < 8; r++) begin
            int ra, rb, rc, rd, rf, rg;
            ra = int'($urandom_range(3))   - 2;
            rb = int'($urandom_range(7))   - 4;
            rc = int'($urandom_range(15))  - 8;
            rd = int'($urandom_range(15))  - 8;
            rf = int'($urandom_range(63))  - 32;
            rg = int'($urandom_range(1023)) - 512;
            computeGolden(ra, rb, rc, rd, rf, rg);
            applyStimulus(ra, rb, rc, rd, rf, rg, done_edge);
            checkOutput($sformatf("rnd%0d_latency", r), done_edge, 35);
            checkDels($sformatf("rnd%0d", r), golden);
        end
        finishRun("rnd");

        // Start re-asserted at E10 and held: ignored while busy, accepted at E36.
        driveCoef(-1, 2, 5, 7, 29, 219);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        ticks = 0;
        tick_edge = -1;
        for (int n = 1; n <= 35; n++) begin
            if (n == 10) begin
                driveCoef(1, 0, 0, 0, 0, 0);
                start = 1'b1;
            end
            @(posedge clk); #1;
            if (done_tick) begin
                ticks++;
                tick_edge = n;
            end
        end
        checkOutput("busy_tick_count", ticks, 1);
        checkOutput("busy_tick_edge", tick_edge, 35);
        checkDels("busy_first", vecs[0].exp);
        @(posedge clk); #1;
        checkOutput("busy_accept_ready", ready, 0);
        checkOutput("busy_accept_tick", done_tick, 0);
        start = 1'b0;
        done_edge = -1;
        for (int n = 1; n <= 60; n++) begin
            @(posedge clk); #1;
            if (done_tick) begin
                done_edge = n;
                break;
            end
        end
        checkOutput("busy_second_latency", done_edge, 35);
        checkDels("busy_second", vecs[1].exp);
        finishRun("busy");

        // Reset at E20 of a run, then a fresh run must show no trace of it.
        driveCoef(-2, 3, 7, -8, 31, -300);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk); #1;
        end
        #30 reset = 1'b1;
        #1;
        checkOutput("mid_rst_ready", ready, 1);
        checkDels("mid_rst", zero_col);
        #10 reset = 1'b0;
        @(posedge clk); #1;
        computeGolden(1, -4, -8, 7, -32, 511);
        applyStimulus(1, -4, -8, 7, -32, 511, done_edge);
        checkOutput("post_rst_latency", done_edge, 35);
        checkDels("post_rst", golden);
        finishRun("post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
